seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode seven-segment display. It owns the digit-select schedule: it steps through digit slots of fixed length, blanks between digits to suppress ghosting, and applies a 16-level brightness duty cycle and a per-digit enable mask. New display data is double-buffered and takes effect only at a frame boundary. It sits between the value-formatting logic and the display pins, replacing ad-hoc two-digit toggle logic.

## Interface
- NUM_DIGITS, 4: digits scanned per frame, 2..8.
- DWELL, 520: cycles per digit slot.
- BLANK, 8: blanking cycles at the start of each slot. (DWELL-BLANK) must be divisible by 16 and BLANK must be ≥1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- digits_in  in  7*NUM_DIGITS  segment patterns; digit d occupies [7d+6:7d].
- load  in  1  single-cycle request to capture digits_in into the pending buffer.
- digit_en  in  NUM_DIGITS  per-digit enable mask, sampled at each slot start.
- brightness  in  4  duty level 0..15, sampled at each slot start.
- segment  out  7  active segment pattern; 0 whenever no anode is on.
- anode  out  NUM_DIGITS  one-hot or zero digit drive.
- frame_start  out  1  one-cycle pulse in cycle 0 of slot 0.
- slot_tick  out  1  one-cycle pulse in cycle 0 of every slot.

## Operation
- Slot counter c runs 0..DWELL-1. Slot index s runs 0..NUM_DIGITS-1 and wraps to 0.
- A disabled digit's slot still elapses, so the frame period is fixed at NUM_DIGITS*DWELL.
- Per-slot FSM:
  - BLANK: c in [0, BLANK).
  - ON: c in [BLANK, BLANK+b*U), where U=(DWELL-BLANK)/16 and b is the latched brightness.
  - OFF: the remaining cycles of the slot.
  - BLANK→ON is skipped when b=0. ON→OFF is immediate when b*U is reached.
  - OFF (or ON, if the slot ends inside it) → BLANK at c=DWELL-1.
- In ON with digit_en[s] latched = 1: anode = 1<<s and segment = active[s].
- In every other state, and in ON with the digit disabled: anode = 0 and segment = 0.
- Brightness 15 gives 15/16 of the non-blank time, never 100%.
- brightness and digit_en are latched in the cycle where c=0. Mid-slot changes are ignored until the next slot.
- load copies digits_in into the pending buffer and sets a pending flag. If load repeats before transfer, the last load wins.
- At the last cycle of the frame (s=NUM_DIGITS-1, c=DWELL-1), a set pending flag copies the pending buffer to the active buffer and clears the flag.
  - If load is asserted in that same cycle, digits_in goes directly to the active buffer and the flag ends cleared.

## Timing
- All outputs are registered. Outputs in cycle t reflect counter and FSM state at cycle t.
- First cycle after rst deasserts: c=0, s=0, frame_start=1, slot_tick=1.
- Reset values:
  - segment=0, anode=0, frame_start=0, slot_tick=0.
  - c=0, s=0, FSM=BLANK, latched brightness=0, latched digit_en=0.
  - active and pending buffers = 0, pending flag = 0.
- rst mid-slot: all outputs are 0 in the following cycle and the scan restarts at slot 0.
- New data is visible no earlier than the first ON cycle of slot 0 of the next frame. Worst-case latency is NUM_DIGITS*DWELL+BLANK cycles.
- anode is never on for two different digits in adjacent cycles; at least BLANK zero cycles separate them.

## Structure
- Package seg_pkg:
  - SEG_W=7.
  - Typedef scan_state_t with values BLANK, ON, OFF.
  - Default DWELL/BLANK localparams.
  - A function computing U.
- Sub-module seg_slot_timer: generates c, s, slot_tick, frame_start and the frame-end strobe.
- seg_scan_ctrl holds the FSM, the buffers and the output registers.

## Test plan
- Reset value check: hold rst 3 cycles → all outputs 0. Release → frame_start=1 in the next cycle, anode=0 for 8 cycles.
- Full brightness, 4 digits: brightness=15, digit_en=4'hF, load patterns 7'h3F/06/5B/4F. Then:
  - anode=0001 for cycles 8..487 of slot 0;
  - anode=0 for cycles 488..527;
  - anode=0010 from cycle 528;
  - segment matches each digit's pattern.
- brightness=0 → anode stays 0 for a full frame. brightness=1 → exactly 32 ON cycles per slot.
- digit_en=4'b1010 → anode never equals 0001 or 0100. frame_start period stays 2080 cycles.
- load 7'h7F in slot 1 → segments stay at the old value through slot 3. New value appears at cycle 8 of the next slot 0.
- load in the frame-end cycle → new data is shown in the next slot 0. rst asserted at c=300 of slot 2 → outputs 0 next cycle and the scan restarts at slot 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_W          width of one digit's segment pattern
//   DEFAULT_DWELL  default cycles per digit slot
//   DEFAULT_BLANK  default blanking cycles at the start of each slot
//   scan_state_t   per-slot drive state (BLANK / ON / OFF)
//   on_unit()      cycles of ON time per brightness step
package seg_pkg;

  localparam int SEG_W         = 7;
  localparam int DEFAULT_DWELL = 520;
  localparam int DEFAULT_BLANK = 8;

  typedef enum logic [1:0] {
    BLANK,
    ON,
    OFF
  } scan_state_t;

  // The non-blank part of a slot is split into 16 equal brightness steps.
  function automatic int on_unit(input int dwell, input int blank);
    return (dwell - blank) / 16;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot/frame timebase for the scan controller.
//   clk, rst     clock, synchronous active-high reset
//   c            cycle-within-slot counter for the current cycle
//   c_nxt        counter value the next cycle will carry
//   s_nxt        slot index the next cycle will carry
//   slot_tick    registered pulse in cycle 0 of every slot
//   frame_start  registered pulse in cycle 0 of slot 0
//   frame_end    combinational strobe in the last cycle of the frame
module seg_slot_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 520,
  parameter int CW         = 10,
  parameter int SW         = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] c,
  output logic [CW-1:0] c_nxt,
  output logic [SW-1:0] s_nxt,
  output logic          slot_tick,
  output logic          frame_start,
  output logic          frame_end
);

  logic [SW-1:0] s;
  // Low only during the first cycle after reset, which holds c=0 so that
  // cycle is the true start of slot 0 and carries the frame_start pulse.
  logic          run;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    c_nxt = c + CW'(1);
    s_nxt = s;
    if (!run) begin
      c_nxt = '0;
      s_nxt = '0;
    end else if (c == CW'(DWELL - 1)) begin
      c_nxt = '0;
      s_nxt = (s == SW'(NUM_DIGITS - 1)) ? '0 : s + SW'(1);
    end
  end

  assign frame_end = (c == CW'(DWELL - 1)) && (s == SW'(NUM_DIGITS - 1));

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      run         <= 1'b0;
      c           <= '0;
      s           <= '0;
      slot_tick   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      run         <= 1'b1;
      c           <= c_nxt;
      s           <= s_nxt;
      slot_tick   <= (c_nxt == '0);
      frame_start <= (c_nxt == '0) && (s_nxt == '0);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-seg display.
//   clk, rst     clock, synchronous active-high reset
//   digits_in    segment patterns, digit d at [7d+6:7d]
//   load         capture digits_in into the pending buffer
//   digit_en     per-digit enable mask, sampled at slot start
//   brightness   duty level 0..15, sampled at slot start
//   segment      segment pattern of the driven digit, 0 when no anode is on
//   anode        one-hot (or zero) digit drive
//   frame_start  pulse in cycle 0 of slot 0
//   slot_tick    pulse in cycle 0 of every slot
// All outputs are registered; each is computed from the counter and FSM
// values of the cycle in which it appears.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = seg_pkg::DEFAULT_DWELL,
  parameter int BLANK      = seg_pkg::DEFAULT_BLANK
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [seg_pkg::SEG_W*NUM_DIGITS-1:0] digits_in,
  input  logic                                 load,
  input  logic [NUM_DIGITS-1:0]                digit_en,
  input  logic [3:0]                           brightness,
  output logic [seg_pkg::SEG_W-1:0]            segment,
  output logic [NUM_DIGITS-1:0]                anode,
  output logic                                 frame_start,
  output logic                                 slot_tick
);

  import seg_pkg::*;

  localparam int U  = on_unit(DWELL, BLANK);
  localparam int CW = $clog2(DWELL);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = SEG_W * NUM_DIGITS;

  logic [CW-1:0]         c, c_nxt, on_end;
  logic [SW-1:0]         s_nxt;
  logic                  frame_end;
  scan_state_t           state, state_nxt;
  logic [3:0]            b_lat, b_nxt;
  logic [NUM_DIGITS-1:0] en_lat, en_nxt;
  logic [DW-1:0]         active, pending;
  logic                  pend_flag;
  logic [SEG_W-1:0]      seg_d;
  logic [NUM_DIGITS-1:0] anode_d;

  seg_slot_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .DWELL     (DWELL),
    .CW        (CW),
    .SW        (SW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .c          (c),
    .c_nxt      (c_nxt),
    .s_nxt      (s_nxt),
    .slot_tick  (slot_tick),
    .frame_start(frame_start),
    .frame_end  (frame_end)
  );

  // Brightness and enable are captured during cycle 0 of a slot; the *_nxt
  // values are what the latches will hold in the next cycle.
  assign b_nxt  = (c == '0) ? brightness : b_lat;
  assign en_nxt = (c == '0) ? digit_en   : en_lat;
  assign on_end = CW'(BLANK + int'(b_nxt) * U);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= seg_pkg::BLANK;
      b_lat  <= '0;
      en_lat <= '0;
    end else begin
      state  <= state_nxt;
      b_lat  <= b_nxt;
      en_lat <= en_nxt;
    end
  end

  // FSM: next state, evaluated against the counter value of the next cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      seg_pkg::BLANK: if (c_nxt == CW'(BLANK)) state_nxt = (b_nxt == '0) ? OFF : ON;
      ON: begin
        if (c_nxt == '0)         state_nxt = seg_pkg::BLANK;
        else if (c_nxt == on_end) state_nxt = OFF;
      end
      OFF:     if (c_nxt == '0) state_nxt = seg_pkg::BLANK;
      default: state_nxt = seg_pkg::BLANK;
    endcase
  end

  // FSM: outputs for the next cycle, registered below
  always_comb begin
    seg_d   = '0;
    anode_d = '0;
    if (state_nxt == ON && en_nxt[s_nxt]) begin
      anode_d = NUM_DIGITS'(1) << s_nxt;
      seg_d   = active[SEG_W*s_nxt +: SEG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segment <= '0;
      anode   <= '0;
    end else begin
      segment <= seg_d;
      anode   <= anode_d;
    end
  end

  // Double buffer. A load in the frame-end cycle bypasses the pending copy.
  // NOTE: both buffers are reset so a blank display is shown until the
  // first load, rather than power-up garbage.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (load) pending <= digits_in;
      if (frame_end) begin
        pend_flag <= 1'b0;
        if (load)           active <= digits_in;
        else if (pend_flag) active <= pending;
      end else if (load) begin
        pend_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, DWELL=520, BLANK=8, U=32).
// Whole frames are captured into arrays, then spot-checked against
// hand-computed cycle positions and ON-cycle counts.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DW    = 520;
  localparam int FRAME = N * DW;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] digits_in;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic [6:0]  segment;
  logic [3:0]  anode;
  logic        frame_start;
  logic        slot_tick;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] an [FRAME];
  logic [6:0] sg [FRAME];
  logic       st [FRAME];

  localparam logic [27:0] D0 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [27:0] D7 = {4{7'h7F}};
  localparam logic [27:0] D1 = {4{7'h55}};
  localparam logic [27:0] D2 = {7'h08, 7'h04, 7'h02, 7'h01};

  seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL(DW), .BLANK(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .load       (load),
    .digit_en   (digit_en),
    .brightness (brightness),
    .segment    (segment),
    .anode      (anode),
    .frame_start(frame_start),
    .slot_tick  (slot_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of frame cycle 0; returns at the negedge of the
  // next frame's cycle 0. Optional loads are driven at frame cycles la / lb.
  task automatic capture(input int la, input logic [27:0] va,
                         input int lb, input logic [27:0] vb);
    for (int k = 0; k < FRAME; k++) begin
      an[k] = anode;
      sg[k] = segment;
      st[k] = slot_tick;
      load  = 1'b0;
      if (k == la) begin load = 1'b1; digits_in = va; end
      if (k == lb) begin load = 1'b1; digits_in = vb; end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  function automatic int on_count(input int slot);
    int n = 0;
    for (int k = slot * DW; k < (slot + 1) * DW; k++)
      if (an[k] != 4'd0) n++;
    return n;
  endfunction

  function automatic int blank_leaks();
    int n = 0;
    for (int k = 0; k < FRAME; k++)
      if (an[k] == 4'd0 && sg[k] != 7'd0) n++;
    return n;
  endfunction

  function automatic int ghosts();
    int n = 0;
    for (int k = 1; k < FRAME; k++)
      if (an[k] != 4'd0 && an[k-1] != 4'd0 && an[k] != an[k-1]) n++;
    return n;
  endfunction

  function automatic int tick_count();
    int n = 0;
    for (int k = 0; k < FRAME; k++)
      if (st[k]) n++;
    return n;
  endfunction

  initial begin
    rst        = 1'b1;
    digits_in  = '0;
    load       = 1'b0;
    digit_en   = 4'hF;
    brightness = 4'd15;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_segment", segment, 0);
    check("rst_anode", anode, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_slot_tick", slot_tick, 0);

    // Release: first cycle is slot 0, cycle 0
    rst = 1'b0;
    @(negedge clk);
    check("first_frame_start", frame_start, 1);
    check("first_slot_tick", slot_tick, 1);

    // Frame 0: buffers still reset, load D0 in cycle 1
    capture(1, D0, -1, '0);
    check("f0_blank_8", an[0] | an[1] | an[2] | an[3] | an[4] | an[5] | an[6] | an[7], 0);
    check("f0_anode_c8", an[8], 4'b0001);
    check("f0_seg_c8_empty", sg[8], 0);
    check("f0_period", frame_start, 1);

    // Frame 1: full brightness, D0 visible
    capture(-1, '0, -1, '0);
    check("f1_anode_c7", an[7], 0);
    check("f1_anode_c8", an[8], 4'b0001);
    check("f1_seg_c8", sg[8], 7'h3F);
    check("f1_anode_c487", an[487], 4'b0001);
    check("f1_anode_c488", an[488], 0);
    check("f1_anode_c527", an[527], 0);
    check("f1_anode_c528", an[528], 4'b0010);
    check("f1_seg_c528", sg[528], 7'h06);
    check("f1_anode_c1048", an[1048], 4'b0100);
    check("f1_seg_c1048", sg[1048], 7'h5B);
    check("f1_anode_c1568", an[1568], 4'b1000);
    check("f1_seg_c1568", sg[1568], 7'h4F);
    check("f1_on_slot0", on_count(0), 480);
    check("f1_blank_leaks", blank_leaks(), 0);
    check("f1_ghosts", ghosts(), 0);
    check("f1_tick_520", {31'd0, st[520]}, 1);
    check("f1_tick_count", tick_count(), 4);
    check("f1_period", frame_start, 1);

    // Frame 2: brightness 0 -> dark for the whole frame
    brightness = 4'd0;
    capture(-1, '0, -1, '0);
    check("b0_on_total", on_count(0) + on_count(1) + on_count(2) + on_count(3), 0);
    check("b0_blank_leaks", blank_leaks(), 0);

    // Frame 3: brightness 1 -> 32 ON cycles per slot
    brightness = 4'd1;
    capture(-1, '0, -1, '0);
    check("b1_on_slot0", on_count(0), 32);
    check("b1_on_slot3", on_count(3), 32);
    check("b1_anode_c39", an[39], 4'b0001);
    check("b1_anode_c40", an[40], 0);

    // Frame 4: mask 1010 -> digits 0 and 2 never lit, period unchanged
    brightness = 4'd15;
    digit_en   = 4'b1010;
    capture(-1, '0, -1, '0);
    check("en_on_slot0", on_count(0), 0);
    check("en_on_slot1", on_count(1), 480);
    check("en_on_slot2", on_count(2), 0);
    check("en_on_slot3", on_count(3), 480);
    check("en_period", frame_start, 1);

    // Frame 5: load 7F mid-frame; old data holds through slot 3
    digit_en = 4'hF;
    capture(600, D7, -1, '0);
    check("ld_hold_slot1", sg[528], 7'h06);
    check("ld_hold_slot3", sg[1568], 7'h4F);

    // Frame 6: new data from cycle 8; then last-load-wins and frame-end load
    capture(1200, D1, FRAME - 1, D2);
    check("ld_new_c7", sg[7], 0);
    check("ld_new_c8", sg[8], 7'h7F);
    check("ld_new_anode_c8", an[8], 4'b0001);
    check("ld_new_slot3", sg[1568], 7'h7F);

    // Frame 7: the frame-end load is live immediately
    capture(-1, '0, -1, '0);
    check("fe_seg_slot0", sg[8], 7'h01);
    check("fe_seg_slot1", sg[528], 7'h02);

    // Reset at c=300 of slot 2
    repeat (2 * DW + 300) @(negedge clk);
    check("mid_anode_before", anode, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_anode", anode, 0);
    check("mid_rst_segment", segment, 0);
    check("mid_rst_frame_start", frame_start, 0);
    check("mid_rst_slot_tick", slot_tick, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_restart_fs", frame_start, 1);
    repeat (8) @(negedge clk);
    check("mid_restart_anode", anode, 4'b0001);
    check("mid_restart_seg_cleared", segment, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
